// File: rtl/cpu_fwd_hazard_unit_if.sv
// ID-stage operand / downstream-stage destination bundle for the forwarding and hazard unit.
// The producer of the pipeline state uses the master view; the hazard unit uses the slave view.
interface cpu_fwd_hazard_unit_if #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 3,
    parameter int REG_ADDR_W = 5
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    logic                             id_valid;
    logic [NUM_SRC-1:0]               src_valid_id;
    logic [NUM_SRC*REG_ADDR_W-1:0]    src_addr_id;
    logic [NUM_STAGES*REG_ADDR_W-1:0] dst_addr_stg;
    logic [NUM_STAGES-1:0]            wb_en_stg;
    logic                             load_stg0;
    logic                             flush;
    logic [NUM_SRC*SEL_W-1:0]         bypass_sel;
    logic                             stall;
    logic                             stall_busy;

    modport master (
        output id_valid, src_valid_id, src_addr_id, dst_addr_stg, wb_en_stg, load_stg0, flush,
        input  bypass_sel, stall, stall_busy
    );

    modport slave (
        input  id_valid, src_valid_id, src_addr_id, dst_addr_stg, wb_en_stg, load_stg0, flush,
        output bypass_sel, stall, stall_busy
    );
endinterface

// File: rtl/cpu_fwd_hazard_unit.sv
// Registered per-operand bypass selection plus a load-use stall FSM with flush override.
// Optional macro FWD_R0_HARDWIRED_EN: register 0 never forwards and never causes a load-use stall.
module cpu_fwd_hazard_unit #(
    parameter int NUM_SRC           = 2,
    parameter int NUM_STAGES        = 3,
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    cpu_fwd_hazard_unit_if.slave    bus
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);
    localparam int CNT_W = 4;

    typedef enum logic {IDLE, STALL} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      stall_q, stall_d;
    logic                      stall_busy_q, stall_busy_d;
    logic [NUM_SRC*SEL_W-1:0]  bypass_sel_q, bypass_sel_d;

    logic [NUM_SRC-1:0][NUM_STAGES-1:0] hit;
    logic [NUM_SRC*SEL_W-1:0]           sel_raw;
    logic                               load_hit;
    logic                               hazard;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                hit[i][k] = bus.src_valid_id[i] && bus.wb_en_stg[k] &&
                            (bus.src_addr_id[i*REG_ADDR_W +: REG_ADDR_W] ==
                             bus.dst_addr_stg[k*REG_ADDR_W +: REG_ADDR_W]);
`ifdef FWD_R0_HARDWIRED_EN
                if (bus.src_addr_id[i*REG_ADDR_W +: REG_ADDR_W] == '0) begin
                    hit[i][k] = 1'b0;
                end
`endif
            end
        end
    end

    // Scan oldest to youngest so the youngest matching stage is the last writer.
    always_comb begin
        sel_raw  = '0;
        load_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (hit[i][k]) begin
                    sel_raw[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
            load_hit = load_hit | hit[i][0];
        end
    end

    assign hazard = bus.id_valid && bus.load_stg0 && load_hit;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_d      = 1'b0;
        stall_busy_d = 1'b0;
        bypass_sel_d = bus.id_valid ? sel_raw : '0;

        if (bus.flush) begin
            state_d      = IDLE;
            cnt_d        = '0;
            bypass_sel_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hazard) begin
                        state_d      = STALL;
                        cnt_d        = CNT_W'(LOAD_STALL_CYCLES - 1);
                        stall_d      = 1'b1;
                        stall_busy_d = 1'b1;
                    end
                end
                STALL: begin
                    // The bubble injected into stage 0 removes the load, so no re-detection here.
                    if (cnt_q != '0) begin
                        cnt_d        = cnt_q - 1'b1;
                        stall_d      = 1'b1;
                        stall_busy_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            stall_q      <= 1'b0;
            stall_busy_q <= 1'b0;
            bypass_sel_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stall_q      <= stall_d;
            stall_busy_q <= stall_busy_d;
            bypass_sel_q <= bypass_sel_d;
        end
    end

    assign bus.bypass_sel = bypass_sel_q;
    assign bus.stall      = stall_q;
    assign bus.stall_busy = stall_busy_q;
endmodule
